uart_receiver: RTL and testbench

Serial-to-parallel UART receiver (8N1, LSB first) that pairs with the team's UART transmitter on the far end of the link. It oversamples the `rx` line using a tick supplied by a baud-rate generator configured for OVERSAMPLE × baud. It locates the middle of each bit and delivers each received byte with a one-cycle done pulse. A bad stop bit is reported as a framing error.

---
 rtl/uart_receiver.sv | 123 ++++++++++++
 tb/tb_uart_receiver.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
`default_nettype none
// uart_receiver: 8N1 LSB-first UART receiver driven by an OVERSAMPLE x baud tick; Rev 1.0
// Define UART_RX_SYNC_EN to pass rx through a 2-flop synchronizer (reset value 1).
module uart_receiver #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       br_tick,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_done,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t          state;
   logic [TW-1:0]   tick_cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shift;
   logic            rx_s;

`ifdef UART_RX_SYNC_EN
   logic [1:0] sync;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync <= 2'b11;
      end else begin
         sync <= {sync[0], rx};
      end
   end

   assign rx_s = sync[1];
`else
   assign rx_s = rx;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         rx_data   <= '0;
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               tick_cnt <= '0;
               // Start detection runs every clk so the edge is caught at full clk resolution.
               if (!rx_s) begin
                  state <= START;
               end
            end
            START: begin
               if (br_tick) begin
                  if (tick_cnt == HALF_LAST) begin
                     tick_cnt <= '0;
                     bit_cnt  <= '0;
                     state    <= rx_s ? IDLE : DATA;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            DATA: begin
               if (br_tick) begin
                  if (tick_cnt == BIT_LAST) begin
                     tick_cnt <= '0;
                     shift    <= {rx_s, shift[7:1]};
                     if (bit_cnt == 3'd7) begin
                        state <= STOP;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            STOP: begin
               if (br_tick) begin
                  if (tick_cnt == BIT_LAST) begin
                     tick_cnt <= '0;
                     state    <= IDLE;
                     if (rx_s) begin
                        rx_data <= shift;
                        rx_done <= 1'b1;
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               tick_cnt <= '0;
            end
         endcase
      end
   end

   assign rx_busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// tb_uart_receiver: table-driven frames plus glitch, reset-abort and tick-stall sequences.
module tb_uart_receiver;

`ifdef UART_RX_SYNC_EN
   localparam int SYNC = 2;
`else
   localparam int SYNC = 0;
`endif
   localparam int LAT = 152 + SYNC;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       br_tick = 1'b1;
   logic       rx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       frame_err;
   logic       rx_busy;

   uart_receiver #(.OVERSAMPLE(16)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .br_tick   (br_tick),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_done   (rx_done),
      .frame_err (frame_err),
      .rx_busy   (rx_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;
   int busy_cnt = 0;
   int last_pulse_cyc = 0;
   int checks = 0;
   int errors = 0;

   // Tick source: every clk, or one clk in ten with an optional stall.
   int  tick_mode = 0;
   int  div = 0;
   logic stall = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_done) begin
         done_cnt       = done_cnt + 1;
         last_pulse_cyc = cyc;
      end
      if (frame_err) begin
         err_cnt        = err_cnt + 1;
         last_pulse_cyc = cyc;
      end
      if (rx_done && frame_err) both_cnt = both_cnt + 1;
      if (rx_busy) busy_cnt = busy_cnt + 1;
   end

   always @(negedge clk) begin
      if (tick_mode == 0) begin
         br_tick = 1'b1;
      end else begin
         div     = (div == 9) ? 0 : div + 1;
         br_tick = (div == 0) && !stall;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input int per, output int start_cyc);
      start_cyc = cyc;
      send_bit(1'b0, per);
      for (int i = 0; i < 8; i++) send_bit(d[i], per);
      send_bit(stop, per);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         gap;
      int         exp_done;
      int         exp_err;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[5];
   int   pulse_at[5];

   initial begin
      int d0, e0, b0, sc;

      vecs[0] = '{8'hA5, 1'b1, 20, 1, 0, 8'hA5};
      vecs[1] = '{8'h3C, 1'b0, 20, 0, 1, 8'hA5};
      vecs[2] = '{8'h00, 1'b1,  0, 1, 0, 8'h00};
      vecs[3] = '{8'hFF, 1'b1, 20, 1, 0, 8'hFF};
      vecs[4] = '{8'hC3, 1'b1, 20, 1, 0, 8'hC3};

      repeat (3) @(negedge clk);
      chk("reset_rx_data", 32'(rx_data), 32'h0);
      chk("reset_rx_done", 32'(rx_done), 32'h0);
      chk("reset_frame_err", 32'(frame_err), 32'h0);
      chk("reset_rx_busy", 32'(rx_busy), 32'h0);
      reset_n = 1'b1;
      send_bit(1'b1, 10);

      for (int i = 0; i < 5; i++) begin
         d0 = done_cnt;
         e0 = err_cnt;
         send_frame(vecs[i].data, vecs[i].stop, 16, sc);
         if (vecs[i].gap > 0) send_bit(1'b1, vecs[i].gap);
         chk($sformatf("v%0d_done", i), 32'(done_cnt - d0), 32'(vecs[i].exp_done));
         chk($sformatf("v%0d_err", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
         chk($sformatf("v%0d_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
         chk($sformatf("v%0d_latency", i), 32'(last_pulse_cyc - sc - 1), 32'(LAT));
         pulse_at[i] = last_pulse_cyc;
      end
      chk("b2b_spacing", 32'(pulse_at[3] - pulse_at[2]), 32'd160);

      // Glitch: 4 clk low must be rejected at the mid start-bit check.
      d0 = done_cnt;
      e0 = err_cnt;
      b0 = busy_cnt;
      send_bit(1'b0, 4);
      send_bit(1'b1, 30);
      chk("glitch_done", 32'(done_cnt - d0), 32'd0);
      chk("glitch_err", 32'(err_cnt - e0), 32'd0);
      chk("glitch_busy_clks", 32'(busy_cnt - b0), 32'd8);
      chk("glitch_data", 32'(rx_data), 32'hC3);

      // Reset during data bit 3 of an 0x77 frame.
      d0 = done_cnt;
      e0 = err_cnt;
      send_bit(1'b0, 16);
      send_bit(1'b1, 16);
      send_bit(1'b1, 16);
      send_bit(1'b1, 16);
      send_bit(1'b0, 8);
      reset_n = 1'b0;
      rx      = 1'b1;
      #1;
      chk("abort_rx_data", 32'(rx_data), 32'h0);
      chk("abort_rx_busy", 32'(rx_busy), 32'h0);
      chk("abort_rx_done", 32'(rx_done), 32'h0);
      chk("abort_frame_err", 32'(frame_err), 32'h0);
      chk("abort_no_pulse", 32'(done_cnt - d0 + err_cnt - e0), 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      send_bit(1'b1, 20);
      d0 = done_cnt;
      send_frame(8'h5A, 1'b1, 16, sc);
      send_bit(1'b1, 20);
      chk("after_reset_done", 32'(done_cnt - d0), 32'd1);
      chk("after_reset_data", 32'(rx_data), 32'h5A);
      chk("after_reset_latency", 32'(last_pulse_cyc - sc - 1), 32'(LAT));

      // Slow tick (1 in 10) with a 40 clk stall inside data bit 2 of 0x81.
      tick_mode = 1;
      send_bit(1'b1, 200);
      d0 = done_cnt;
      e0 = err_cnt;
      send_bit(1'b0, 160);
      send_bit(1'b1, 160);
      send_bit(1'b0, 160);
      rx = 1'b0;
      repeat (10) @(negedge clk);
      stall = 1'b1;
      b0 = busy_cnt;
      repeat (40) @(negedge clk);
      chk("stall_busy_held", 32'(busy_cnt - b0), 32'd40);
      chk("stall_no_pulse", 32'(done_cnt - d0 + err_cnt - e0), 32'd0);
      stall = 1'b0;
      repeat (150) @(negedge clk);
      for (int i = 3; i < 7; i++) send_bit(1'b0, 160);
      send_bit(1'b1, 160);
      send_bit(1'b1, 160);
      send_bit(1'b1, 100);
      chk("stall_done", 32'(done_cnt - d0), 32'd1);
      chk("stall_err", 32'(err_cnt - e0), 32'd0);
      chk("stall_data", 32'(rx_data), 32'h81);
      chk("stall_idle_after", 32'(rx_busy), 32'h0);

      chk("done_err_overlap", 32'(both_cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
